line_endpoint_sync: RTL and testbench
=====================================

LINE_ENDPOINT_SYNC -- requirements
Module: line_endpoint_sync

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 8, frames without an update before the line is deactivated (legal range 1..255).
REQ-004 SHALL have clk_in  input  1  the single clock, which is the pixel clock.
REQ-005 SHALL have rst_in  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have hcount_in  input  11  and vcount_in  input  10  raster position.
REQ-007 SHALL have ep_x1_in, ep_x2_in  input  11 each  and ep_y1_in, ep_y2_in  input  10 each  candidate endpoints.
REQ-008 SHALL have ep_valid_in  input  1  (candidate present) and ep_ready_out  output  1  (candidate accepted).
REQ-009 SHALL have x1_out, x2_out  output  11 each  and y1_out, y2_out  output  10 each  committed endpoints for the line sprite.
REQ-010 SHALL have line_active_out  output  1  and sprite_rst_out  output  1  (active-high restart pulse to the sprite).
REQ-011 SHALL have drop_count_out  output  8  saturating count of overwritten pending updates.

Function
REQ-012 SHALL hold ep_ready_out at 1 whenever rst_in is high; a transfer is ep_valid_in and ep_ready_out both high on a rising edge.
REQ-013 SHALL clamp each accepted x to min(x, H_ACTIVE-1) and each y to min(y, V_ACTIVE-1) before storing it in a one-entry pending register.
REQ-014 SHALL replace the contents of a full pending register on a new transfer (latest wins) and increment drop_count_out, saturating at 255.
REQ-015 SHALL define the frame-boundary cycle as hcount_in == 0 and vcount_in == V_ACTIVE, which is the first cycle of vertical blanking.
REQ-016 SHALL, on the boundary cycle with pending full, do all of the following on the next edge: copy pending to the x/y outputs, clear pending, clear the miss counter and enter LIVE.
REQ-017 SHALL, on the boundary cycle with pending empty, increment the miss counter, saturating at TIMEOUT_FRAMES.
REQ-018 SHALL enter EMPTY when the miss counter reaches TIMEOUT_FRAMES, with no other output change.
REQ-019 SHALL implement a two-state FSM: EMPTY (line_active_out=0) and LIVE (line_active_out=1).
  - EMPTY->LIVE only on a commit.
  - LIVE->EMPTY only on timeout.
  - A commit while LIVE stays LIVE.
REQ-020 SHALL, on a transfer during the boundary cycle, commit the previously pending value and place the new candidate in pending; the new candidate is not counted as a drop.
REQ-021 SHALL assert sprite_rst_out for exactly one cycle, in the cycle after each commit, so the sprite restarts its walk from the new x1/y1.
REQ-022 SHALL keep the x/y outputs stable between commits; a timeout clears line_active_out but not the coordinates.
REQ-023 SHALL have one-cycle latency from the boundary cycle to updated outputs, and no combinational path from ep_* inputs to any output.
REQ-024 SHALL treat equal endpoints as a legal line; no special case.

Reset
REQ-025 SHALL, while rst_in is low, set:
  - x/y outputs to 0, line_active_out to 0, drop_count_out to 0;
  - pending to empty, miss counter to 0, FSM to EMPTY;
  - ep_ready_out to 0 and sprite_rst_out to 1.
REQ-026 SHALL discard any pending update when reset is asserted mid-frame; the first commit after reset needs a fresh transfer.
REQ-027 SHALL drive sprite_rst_out to 0 in the first cycle after rst_in returns high, unless a commit occurred.

Structure
REQ-028 SHALL take the FSM state enum and the raster constants (H_ACTIVE, V_ACTIVE defaults, coordinate widths) from the shared video package used by the sprite modules.
REQ-029 SHALL instantiate one sub-module, coord_clamp, which is a registered two-axis clamp reused for the x and y pairs; everything else is inline.

Verification
REQ-030 Transfer (100,50,900,400) at vcount 10; at boundary -> next cycle outputs=(100,50,900,400), line_active_out=1, one sprite_rst_out pulse.
REQ-031 Transfer (1500,800,20,30) -> committed (1279,719,20,30).
REQ-032 Three transfers in one frame, last (5,5,6,6) -> commit (5,5,6,6); drop_count_out=2.
REQ-033 Transfer A before the boundary and B exactly on the boundary cycle -> A commits; B commits at the next boundary; drop_count_out unchanged.
REQ-034 One commit, then no transfers, TIMEOUT_FRAMES=8 -> line_active_out falls the cycle after the 8th empty boundary; coordinates hold.
REQ-035 Pending full, rst_in low for 1 cycle mid-frame -> all outputs at reset values; the next boundary produces no commit and line_active_out stays 0.

Source files
------------

// File: rtl/line_endpoint_sync_pkg.sv
// Shared video package: raster constants, coordinate widths and the line FSM state.
// Imported by the endpoint synchroniser and the sprite modules.
package line_endpoint_sync_pkg;

    localparam int X_W              = 11;
    localparam int Y_W              = 10;
    localparam int CNT_W            = 8;
    localparam int H_ACTIVE_DEFAULT = 1280;
    localparam int V_ACTIVE_DEFAULT = 720;

    typedef enum logic {
        EMPTY = 1'b0,
        LIVE  = 1'b1
    } line_state_t;

    // Saturating increment used by both the drop and miss counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + 8'd1;
    endfunction

endpackage

// File: rtl/line_endpoint_sync_if.sv
// Candidate-endpoint handshake, raster position and committed line endpoints.
// The producer/raster side uses master; the synchroniser uses slave.
interface line_endpoint_sync_if;
    import line_endpoint_sync_pkg::*;

    logic [X_W-1:0]   hcount_in;
    logic [Y_W-1:0]   vcount_in;
    logic [X_W-1:0]   ep_x1_in;
    logic [X_W-1:0]   ep_x2_in;
    logic [Y_W-1:0]   ep_y1_in;
    logic [Y_W-1:0]   ep_y2_in;
    logic             ep_valid_in;
    logic             ep_ready_out;
    logic [X_W-1:0]   x1_out;
    logic [X_W-1:0]   x2_out;
    logic [Y_W-1:0]   y1_out;
    logic [Y_W-1:0]   y2_out;
    logic             line_active_out;
    logic             sprite_rst_out;
    logic [CNT_W-1:0] drop_count_out;

    modport master (
        output hcount_in, vcount_in, ep_x1_in, ep_x2_in, ep_y1_in, ep_y2_in, ep_valid_in,
        input  ep_ready_out, x1_out, x2_out, y1_out, y2_out,
        input  line_active_out, sprite_rst_out, drop_count_out
    );

    modport slave (
        input  hcount_in, vcount_in, ep_x1_in, ep_x2_in, ep_y1_in, ep_y2_in, ep_valid_in,
        output ep_ready_out, x1_out, x2_out, y1_out, y2_out,
        output line_active_out, sprite_rst_out, drop_count_out
    );

endinterface

// File: rtl/line_endpoint_sync_coord_clamp.sv
// Registered two-axis clamp: on load, stores one (x, y) point limited to the active area.
// rst_n is synchronous and active-low; the stored point returns to the origin.
module coord_clamp
    import line_endpoint_sync_pkg::*;
#(
    parameter logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE_DEFAULT - 1),
    parameter logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE_DEFAULT - 1)
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic [X_W-1:0] x_clamped,
    output logic [Y_W-1:0] y_clamped
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_clamped <= '0;
            y_clamped <= '0;
        end else if (load) begin
            x_clamped <= (x > X_MAX) ? X_MAX : x;
            y_clamped <= (y > Y_MAX) ? Y_MAX : y;
        end
    end

endmodule

// File: rtl/line_endpoint_sync.sv
// Accepts candidate line endpoints at any time and commits the latest one on the first
// cycle of vertical blanking, deactivating the line after TIMEOUT_FRAMES frames without one.
module line_endpoint_sync
    import line_endpoint_sync_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
    parameter int TIMEOUT_FRAMES = 8
)(
    input logic                 clk_in,
    input logic                 rst_in,
    line_endpoint_sync_if.slave bus
);

    localparam logic [X_W-1:0]   X_MAX      = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_MAX      = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0]   V_BOUNDARY = Y_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(TIMEOUT_FRAMES);

    logic             transfer;
    logic             boundary;
    logic             commit;
    logic             pending_full;
    logic [X_W-1:0]   pend_x1, pend_x2;
    logic [Y_W-1:0]   pend_y1, pend_y2;
    logic [X_W-1:0]   x1, x2;
    logic [Y_W-1:0]   y1, y2;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] miss;
    logic [CNT_W-1:0] miss_next;
    logic             sprite_rst;
    logic             line_active;
    line_state_t      state, state_next;

    // Ready is simply "out of reset", so no ep_* input can reach an output combinationally.
    assign bus.ep_ready_out = rst_in;
    assign transfer = bus.ep_valid_in && bus.ep_ready_out;
    assign boundary = (bus.hcount_in == '0) && (bus.vcount_in == V_BOUNDARY);
    assign commit   = boundary && pending_full;

    coord_clamp #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) clamp_p1 (
        .clk(clk_in), .rst_n(rst_in), .load(transfer),
        .x(bus.ep_x1_in), .y(bus.ep_y1_in), .x_clamped(pend_x1), .y_clamped(pend_y1)
    );

    coord_clamp #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) clamp_p2 (
        .clk(clk_in), .rst_n(rst_in), .load(transfer),
        .x(bus.ep_x2_in), .y(bus.ep_y2_in), .x_clamped(pend_x2), .y_clamped(pend_y2)
    );

    // A transfer on the boundary cycle refills pending as the old value commits; not a drop.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending_full <= 1'b0;
            x1           <= '0;
            x2           <= '0;
            y1           <= '0;
            y2           <= '0;
            drop_count   <= '0;
            miss         <= '0;
            sprite_rst   <= 1'b1;
        end else begin
            if (transfer)
                pending_full <= 1'b1;
            else if (commit)
                pending_full <= 1'b0;
            if (commit) begin
                x1 <= pend_x1;
                y1 <= pend_y1;
                x2 <= pend_x2;
                y2 <= pend_y2;
            end
            if (transfer && pending_full && !boundary)
                drop_count <= sat_inc(drop_count, 8'hFF);
            miss       <= miss_next;
            sprite_rst <= commit;
        end
    end

    always_comb begin
        miss_next = miss;
        if (commit)
            miss_next = '0;
        else if (boundary)
            miss_next = sat_inc(miss, TIMEOUT);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (commit)
            state_next = LIVE;
        else if (miss_next == TIMEOUT)
            state_next = EMPTY;
    end

    always_comb begin
        line_active = (state == LIVE);
    end

    assign bus.x1_out          = x1;
    assign bus.x2_out          = x2;
    assign bus.y1_out          = y1;
    assign bus.y2_out          = y2;
    assign bus.line_active_out = line_active;
    assign bus.sprite_rst_out  = sprite_rst;
    assign bus.drop_count_out  = drop_count;

endmodule

// File: tb/tb_line_endpoint_sync.sv
// Directed bench for line_endpoint_sync: raster position is driven directly so each
// frame boundary is a single chosen cycle rather than a full simulated frame.
module tb_line_endpoint_sync;
    import line_endpoint_sync_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    line_endpoint_sync_if bus();

    line_endpoint_sync #(
        .H_ACTIVE(1280), .V_ACTIVE(720), .TIMEOUT_FRAMES(8)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input int h, input int v,
                                  input int x1, input int y1, input int x2, input int y2);
        bus.hcount_in   = 11'(h);
        bus.vcount_in   = 10'(v);
        bus.ep_x1_in    = 11'(x1);
        bus.ep_y1_in    = 10'(y1);
        bus.ep_x2_in    = 11'(x2);
        bus.ep_y2_in    = 10'(y2);
        bus.ep_valid_in = valid;
        tick();
        bus.ep_valid_in = 1'b0;
    endtask

    task automatic idle(input int h, input int v);
        apply_stimulus(1'b0, h, v, 0, 0, 0, 0);
    endtask

    task automatic frame_boundary();
        idle(0, 720);
    endtask

    task automatic check_output(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_coords(input string tag, input int x1, input int y1,
                                input int x2, input int y2);
        check_output({tag, ".x1"}, int'(bus.x1_out), x1);
        check_output({tag, ".y1"}, int'(bus.y1_out), y1);
        check_output({tag, ".x2"}, int'(bus.x2_out), x2);
        check_output({tag, ".y2"}, int'(bus.y2_out), y2);
    endtask

    initial begin
        bus.hcount_in   = '0;
        bus.vcount_in   = '0;
        bus.ep_x1_in    = '0;
        bus.ep_y1_in    = '0;
        bus.ep_x2_in    = '0;
        bus.ep_y2_in    = '0;
        bus.ep_valid_in = 1'b0;

        idle(5, 5);
        idle(5, 5);
        check_coords("reset", 0, 0, 0, 0);
        check_output("reset.active", int'(bus.line_active_out), 0);
        check_output("reset.drop", int'(bus.drop_count_out), 0);
        check_output("reset.ready", int'(bus.ep_ready_out), 0);
        check_output("reset.sprite_rst", int'(bus.sprite_rst_out), 1);

        rst = 1'b1;
        #1;
        check_output("release.ready", int'(bus.ep_ready_out), 1);
        idle(5, 5);
        check_output("release.sprite_rst", int'(bus.sprite_rst_out), 0);

        // Basic commit at the boundary
        apply_stimulus(1'b1, 3, 10, 100, 50, 900, 400);
        check_coords("precommit", 0, 0, 0, 0);
        check_output("precommit.active", int'(bus.line_active_out), 0);
        frame_boundary();
        check_coords("commit1", 100, 50, 900, 400);
        check_output("commit1.active", int'(bus.line_active_out), 1);
        check_output("commit1.sprite_rst", int'(bus.sprite_rst_out), 1);
        idle(1, 721);
        check_output("commit1.sprite_rst_end", int'(bus.sprite_rst_out), 0);

        // Clamping
        apply_stimulus(1'b1, 40, 30, 1500, 800, 20, 30);
        frame_boundary();
        check_coords("clamp", 1279, 719, 20, 30);
        check_output("clamp.drop", int'(bus.drop_count_out), 0);

        // Latest of three wins, two drops
        apply_stimulus(1'b1, 7, 100, 10, 10, 10, 10);
        apply_stimulus(1'b1, 8, 100, 20, 20, 20, 20);
        apply_stimulus(1'b1, 9, 100, 5, 5, 6, 6);
        check_output("three.drop", int'(bus.drop_count_out), 2);
        frame_boundary();
        check_coords("three", 5, 5, 6, 6);
        check_output("three.sprite_rst", int'(bus.sprite_rst_out), 1);

        // Transfer on the boundary cycle itself
        apply_stimulus(1'b1, 50, 50, 200, 100, 300, 150);
        apply_stimulus(1'b1, 0, 720, 400, 200, 500, 250);
        check_coords("onbound.A", 200, 100, 300, 150);
        check_output("onbound.drop", int'(bus.drop_count_out), 2);
        idle(3, 5);
        idle(4, 5);
        check_coords("onbound.hold", 200, 100, 300, 150);
        frame_boundary();
        check_coords("onbound.B", 400, 200, 500, 250);
        check_output("onbound.drop2", int'(bus.drop_count_out), 2);

        // Timeout after eight empty boundaries
        for (int f = 0; f < 7; f++) begin
            idle(10, 5);
            frame_boundary();
        end
        check_output("timeout7.active", int'(bus.line_active_out), 1);
        idle(10, 5);
        frame_boundary();
        check_output("timeout8.active", int'(bus.line_active_out), 0);
        check_coords("timeout.hold", 400, 200, 500, 250);
        check_output("timeout.sprite_rst", int'(bus.sprite_rst_out), 0);

        // Drop counter saturation, equal endpoints
        for (int i = 0; i < 260; i++)
            apply_stimulus(1'b1, 20, 200, i, i, i, i);
        check_output("sat.drop", int'(bus.drop_count_out), 255);
        frame_boundary();
        check_coords("sat.commit", 259, 259, 259, 259);
        check_output("sat.active", int'(bus.line_active_out), 1);

        // Reset mid-frame discards pending
        apply_stimulus(1'b1, 30, 20, 7, 8, 9, 10);
        rst = 1'b0;
        idle(31, 20);
        check_coords("midrst", 0, 0, 0, 0);
        check_output("midrst.active", int'(bus.line_active_out), 0);
        check_output("midrst.drop", int'(bus.drop_count_out), 0);
        check_output("midrst.ready", int'(bus.ep_ready_out), 0);
        check_output("midrst.sprite_rst", int'(bus.sprite_rst_out), 1);
        rst = 1'b1;
        idle(32, 20);
        check_output("midrst.sprite_rst_end", int'(bus.sprite_rst_out), 0);
        frame_boundary();
        check_output("midrst.bound.active", int'(bus.line_active_out), 0);
        check_output("midrst.bound.sprite_rst", int'(bus.sprite_rst_out), 0);
        check_coords("midrst.bound", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
